// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Contents: fetch FSM state, redirect kind, instruction/jump-index widths,
// default reset PC and the redirect priority helper (Jump > JumpReg > PCSrc).
package mips_fetch_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam int unsigned JIMM_W           = 26;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      JUMP   = 2'd1,
      JREG   = 2'd2,
      BRANCH = 2'd3
   } redirect_kind_t;

   // Resolve simultaneous redirect requests by fixed priority.
   function automatic redirect_kind_t redirect_select(input logic jump,
                                                      input logic jreg,
                                                      input logic branch);
      redirect_kind_t kind;
      kind = NONE;
      if (jump) begin
         kind = JUMP;
      end else if (jreg) begin
         kind = JREG;
      end else if (branch) begin
         kind = BRANCH;
      end
      return kind;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decode valid/ready handshake
// and the redirect inputs returned by decode for the consumed instruction.
// Modports:
//   master - fetch unit side (drives imem_req/imem_addr, instruction/Ins_Addr/out_valid)
//   slave  - memory/decoder side (drives imem_rdata, out_ready and redirect inputs)
interface pc_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();
   import mips_fetch_pkg::*;

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic [INSTR_W-1:0]  imem_rdata;

   logic [INSTR_W-1:0]  instruction;
   logic [ADDR_W-1:0]   Ins_Addr;
   logic                out_valid;
   logic                out_ready;

   logic                Jump;
   logic [JIMM_W-1:0]   Jump_immediate;
   logic                JumpReg;
   logic [ADDR_W-1:0]   jr_target;
   logic                PCSrc;
   logic [31:0]         PCSrc_immediate;

   modport master (
      output imem_req, imem_addr, instruction, Ins_Addr, out_valid,
      input  imem_rdata, out_ready, Jump, Jump_immediate, JumpReg, jr_target,
             PCSrc, PCSrc_immediate
   );

   modport slave (
      input  imem_req, imem_addr, instruction, Ins_Addr, out_valid,
      output imem_rdata, out_ready, Jump, Jump_immediate, JumpReg, jr_target,
             PCSrc, PCSrc_immediate
   );

endinterface

// File: rtl/pc_fetch_unit_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of {instruction, PC} for the fetch stage.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push, wdata - write one entry (caller guarantees space, possibly via same-cycle pop)
//   pop         - drop head entry (ignored when empty)
//   flush       - discard all entries; overrides push/pop
//   rdata       - head entry
//   count       - current occupancy
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_ok;

   assign pop_ok = pop && (count != '0);
   assign rdata  = mem[rd_ptr];

   // Storage, pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Owns the PC, issues reads to a
// 1-cycle-latency instruction memory, buffers {instruction, PC} and hands them to
// decode over valid/ready. Jump / JumpReg / PCSrc redirects are taken on the
// consume cycle; wrong-path work is flushed and in-flight reads killed by an epoch bit.
// Ports:
//   CLK, RST - clock (rising edge), asynchronous active-high reset
//   bus      - pc_fetch_unit_if.master (imem port, decode handshake, redirect inputs)
// Optional feature: define FETCH_DELAY_SLOT_EN to deliver the branch delay slot
// before the redirect flush takes effect (adds the PEND state).
module pc_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned       BUF_DEPTH = 2
) (
   input logic             CLK,
   input logic             RST,
   pc_fetch_unit_if.master bus
);

   localparam int unsigned PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              epoch_q;
   logic              resp_valid_q;
   logic              resp_epoch_q;
   logic [ADDR_W-1:0] resp_pc_q;
`ifdef FETCH_DELAY_SLOT_EN
   logic [ADDR_W-1:0] pend_pc_q;
`endif

   logic [CNT_W-1:0]   occupancy;
   logic [ENTRY_W-1:0] head;
   logic               consume;
   logic               issue;
   logic               push;
   logic               flush;
   logic               redirect_take;
   redirect_kind_t     kind;
   logic [ADDR_W-1:0]  base;
   logic [ADDR_W-1:0]  jump_target;
   logic [ADDR_W-1:0]  jreg_target;
   logic [ADDR_W-1:0]  branch_target;
   logic [ADDR_W-1:0]  target;
   logic [ADDR_W-1:0]  flush_pc;

   assign consume = bus.out_valid && bus.out_ready;

   // Credit check counts the in-flight read and frees the slot popped this cycle,
   // so a 2-entry buffer sustains one instruction per cycle.
   assign issue = (state_q != BOOT) &&
                  ((SUM_W'(occupancy) + SUM_W'(resp_valid_q)) <
                   (SUM_W'(BUF_DEPTH) + SUM_W'(consume)));

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc_q;

   // Redirect target computation relative to the consumed instruction.
   assign base          = bus.Ins_Addr + ADDR_W'(4);
   assign jump_target   = (base & ~ADDR_W'(28'hFFF_FFFF)) |
                          ADDR_W'({bus.Jump_immediate, 2'b00});
   assign jreg_target   = bus.jr_target & ~ADDR_W'(3);
   assign branch_target = base + ADDR_W'({{ADDR_W{bus.PCSrc_immediate[31]}},
                                          bus.PCSrc_immediate, 2'b00});

   always_comb begin
      kind   = redirect_select(bus.Jump, bus.JumpReg, bus.PCSrc);
      target = base;
      case (kind)
         JUMP:    target = jump_target;
         JREG:    target = jreg_target;
         BRANCH:  target = branch_target;
         default: target = base;
      endcase
   end

   assign redirect_take = consume && (kind != NONE) && (state_q == RUN);

`ifdef FETCH_DELAY_SLOT_EN
   // Flush is deferred until the delay-slot instruction is consumed.
   assign flush    = consume && (state_q == PEND);
   assign flush_pc = pend_pc_q;
`else
   assign flush    = redirect_take;
   assign flush_pc = target;
`endif

   // Responses from a previous epoch, or arriving during a flush, are dropped.
   assign push = resp_valid_q && (resp_epoch_q == epoch_q) && !flush;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_buffer (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (consume),
      .flush (flush),
      .wdata ({bus.imem_rdata, resp_pc_q}),
      .rdata (head),
      .count (occupancy)
   );

   assign bus.instruction = head[ENTRY_W-1:ADDR_W];
   assign bus.Ins_Addr    = head[ADDR_W-1:0];
   assign bus.out_valid   = (occupancy != '0);

   // PC, epoch, in-flight tracking and fetch FSM.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         epoch_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_epoch_q <= 1'b0;
         resp_pc_q    <= '0;
`ifdef FETCH_DELAY_SLOT_EN
         pend_pc_q    <= '0;
`endif
      end else begin
         // A request issued in the flush cycle carries the old epoch and dies.
         resp_valid_q <= issue;
         resp_epoch_q <= epoch_q;
         resp_pc_q    <= pc_q;

         if (flush) begin
            epoch_q <= ~epoch_q;
            pc_q    <= flush_pc;
         end else if (issue) begin
            pc_q <= pc_q + ADDR_W'(4);
         end

         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
`ifdef FETCH_DELAY_SLOT_EN
               if (redirect_take) begin
                  state_q   <= PEND;
                  pend_pc_q <= target;
               end
`endif
            end
`ifdef FETCH_DELAY_SLOT_EN
            PEND: begin
               if (consume) begin
                  state_q <= RUN;
               end
            end
`endif
            default: state_q <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with a 1-cycle memory
// returning PC>>2 as the instruction word.
module tb_pc_fetch_unit;
   import mips_fetch_pkg::*;

   localparam int unsigned ADDR_W = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_checks = 0;
   int          n_fail = 0;
   int          bad_hits = 0;
   int          hits_snap = 0;
   logic [31:0] bad_addr = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   pc_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   pc_fetch_unit #(
      .ADDR_W    (ADDR_W),
      .RESET_PC  (32'h0000_3000),
      .BUF_DEPTH (2)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Instruction memory: data for address A is A>>2, one cycle after the request.
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= 32'(bus.imem_addr >> 2);
   end

   // Counts deliveries of an address that must not reach decode.
   always @(posedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready && bus.Ins_Addr == bad_addr)
         bad_hits <= bad_hits + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirect();
      bus.Jump            = 1'b0;
      bus.Jump_immediate  = '0;
      bus.JumpReg         = 1'b0;
      bus.jr_target       = '0;
      bus.PCSrc           = 1'b0;
      bus.PCSrc_immediate = '0;
   endtask

   task automatic wait_head(input string tag, input logic [31:0] addr, input int budget);
      int n = 0;
      while (!(bus.out_valid && bus.Ins_Addr == addr) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, addr}));
   endtask

   initial begin
      clear_redirect();
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick(); tick(); tick();

      // Reset state
      check("rst_req",   64'(bus.imem_req),    64'h0);
      check("rst_valid", 64'(bus.out_valid),   64'h0);
      check("rst_instr", 64'(bus.instruction), 64'h0);
      check("rst_iaddr", 64'(bus.Ins_Addr),    64'h0);
      check("rst_pc",    64'(bus.imem_addr),   64'h3000);

      // 1: sequential fetch, first valid two cycles after reset release
      rst = 1'b0;
      tick();
      check("boot_req",  64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, 32'h3000}));
      check("boot_v0",   64'(bus.out_valid), 64'h0);
      tick();
      check("boot_v1",   64'(bus.out_valid), 64'h0);
      tick();
      check("seq_3000",  64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3000}));
      check("seq_instr", 64'(bus.instruction), 64'hC00);
      tick();
      check("seq_3004",  64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3004}));
      tick();
      check("seq_3008",  64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3008}));

      // 2: backpressure; redirect inputs without a consume are ignored
      bus.out_ready = 1'b0;
      bus.Jump      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_head", 64'({bus.out_valid, bus.Ins_Addr, bus.instruction}),
               64'({1'b1, 32'h3008, 32'hC02}));
         check("stall_req",  64'(bus.imem_req), 64'h0);
      end
      clear_redirect();
      bus.out_ready = 1'b1;
      tick();
      check("rel_300c", 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h300C}));
      tick();
      check("rel_3010", 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3010}));

      // 3: backward branch at 0x3010, imm=-4 -> 0x3004; 0x3014 is wrong-path
      bad_addr            = 32'h3014;
      bus.PCSrc           = 1'b1;
      bus.PCSrc_immediate = 32'hFFFF_FFFC;
      tick();
      clear_redirect();
      check("br_flush0", 64'(bus.out_valid), 64'h0);
      tick();
      check("br_flush1", 64'(bus.out_valid), 64'h0);
      tick();
      check("br_target", 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3004}));

      // 4: Jump and PCSrc together at 0x3010 -> Jump wins, target 0x400
      wait_head("reach_3010", 32'h3010, 8);
      bus.Jump            = 1'b1;
      bus.Jump_immediate  = 26'h000_0100;
      bus.PCSrc           = 1'b1;
      bus.PCSrc_immediate = 32'h0000_0010;
      tick();
      clear_redirect();
      check("jmp_flush", 64'(bus.out_valid), 64'h0);
      tick(); tick();
      check("jmp_target", 64'({bus.out_valid, bus.Ins_Addr, bus.instruction}),
            64'({1'b1, 32'h0000_0400, 32'h100}));
      check("no_3014", 64'(bad_hits), 64'h0);

      // JumpReg at 0x400 to 0x3021 (low bits masked -> 0x3020)
      hits_snap = bad_hits;
`ifdef FETCH_DELAY_SLOT_EN
      bad_addr = 32'h408;
`else
      bad_addr = 32'h404;
`endif
      bus.JumpReg   = 1'b1;
      bus.jr_target = 32'h3021;
      tick();
      clear_redirect();
`ifdef FETCH_DELAY_SLOT_EN
      check("ds_404", 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h404}));
`else
      check("jr_flush", 64'(bus.out_valid), 64'h0);
`endif
      wait_head("jr_3020", 32'h3020, 6);
      check("jr_wrongpath", 64'(bad_hits - hits_snap), 64'h0);

      // 5: JumpReg at 0x3020 to 0x3101 -> 0x3100 (delay slot 0x3024 when enabled)
      hits_snap = bad_hits;
`ifdef FETCH_DELAY_SLOT_EN
      bad_addr = 32'h3028;
`else
      bad_addr = 32'h3024;
`endif
      bus.JumpReg   = 1'b1;
      bus.jr_target = 32'h3101;
      tick();
      clear_redirect();
`ifdef FETCH_DELAY_SLOT_EN
      check("ds_3024", 64'({bus.out_valid, bus.Ins_Addr}), 64'({1'b1, 32'h3024}));
      bus.Jump           = 1'b1;
      bus.Jump_immediate = 26'h000_03FF;
      tick();
      clear_redirect();
`endif
      check("jr2_flush", 64'(bus.out_valid), 64'h0);
      tick(); tick();
      check("jr2_target", 64'({bus.out_valid, bus.Ins_Addr, bus.instruction}),
            64'({1'b1, 32'h3100, 32'hC40}));
      check("jr2_wrongpath", 64'(bad_hits - hits_snap), 64'h0);
      bad_addr = 32'hFFFF_FFFF;

      // 6: reset with a read in flight
      tick();
      check("pre_rst_req", 64'(bus.imem_req), 64'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_out", 64'({bus.imem_req, bus.out_valid, bus.instruction, bus.Ins_Addr}),
            64'h0);
      check("mid_rst_pc", 64'(bus.imem_addr), 64'h3000);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("re_v0", 64'(bus.out_valid), 64'h0);
      tick();
      check("re_v1", 64'(bus.out_valid), 64'h0);
      tick();
      check("re_3000", 64'({bus.out_valid, bus.Ins_Addr, bus.instruction}),
            64'({1'b1, 32'h3000, 32'hC00}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
